div_seq: RTL and testbench

//  Multi-cycle unsigned restoring divider used by the M-extension execute stage (DIV/DIVU/REM/REMU).

---
 rtl/div_seq_pkg.sv | 12 +
 rtl/div_seq_if.sv | 21 ++
 rtl/div_seq_step.sv | 21 ++
 rtl/div_seq.sv | 94 +++++++++
 tb/tb_div_seq.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_seq_pkg;

   localparam int DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div_seq_if.sv
// Request/ready bundle between the execute stage (master) and the divider (slave).
interface div_seq_if #(
   parameter int XLEN = div_seq_pkg::DATA_WIDTH
);
   logic [XLEN-1:0] dividend_in;
   logic [XLEN-1:0] divisor_in;
   logic            req_in;
   logic            rem_sel_in;
   logic            ready_out;
   logic [XLEN-1:0] result_out;

   modport master (
      output dividend_in, divisor_in, req_in, rem_sel_in,
      input  ready_out, result_out
   );

   modport slave (
      input  dividend_in, divisor_in, req_in, rem_sel_in,
      output ready_out, result_out
   );
endinterface

// File: rtl/div_seq_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module div_seq_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic            dvd_bit_in,
   input  logic [XLEN-1:0] divisor_in,
   output logic [XLEN-1:0] rem_out,
   output logic            q_bit_out
);

   logic [XLEN:0] rem_shift;

   // Trial subtraction; the difference always fits in XLEN bits because it is below the divisor.
   always_comb begin
      rem_shift = {rem_in, dvd_bit_in};
      q_bit_out = (rem_shift >= {1'b0, divisor_in});
      rem_out   = q_bit_out ? (rem_shift[XLEN-1:0] - divisor_in) : rem_shift[XLEN-1:0];
   end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// The dividend register doubles as the quotient register: each step shifts a
// dividend bit out of the top and the new quotient bit into the bottom.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int XLEN = DATA_WIDTH
) (
   input  logic      clk_in,
   input  logic      reset_in,
   div_seq_if.slave  bus
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [XLEN-1:0]  dq_q;
   logic [XLEN-1:0]  dsr_q;
   logic [XLEN-1:0]  rem_q;
   logic [XLEN-1:0]  rem_nxt;
   logic [XLEN-1:0]  result_q;
   logic             rem_sel_q;
   logic             ready_q;
   logic             q_bit;

   div_seq_step #(.XLEN(XLEN)) u_step (
      .rem_in     (rem_q),
      .dvd_bit_in (dq_q[XLEN-1]),
      .divisor_in (dsr_q),
      .rem_out    (rem_nxt),
      .q_bit_out  (q_bit)
   );

   // Control FSM with operand/shift registers and registered result/ready.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state     <= ST_IDLE;
         count     <= '0;
         dq_q      <= '0;
         dsr_q     <= '0;
         rem_q     <= '0;
         rem_sel_q <= 1'b0;
         result_q  <= '0;
         ready_q   <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.req_in) begin
                  dq_q      <= bus.dividend_in;
                  dsr_q     <= bus.divisor_in;
                  rem_sel_q <= bus.rem_sel_in;
                  rem_q     <= '0;
                  count     <= '0;
                  if (bus.divisor_in == '0) begin
                     // Division by zero: quotient all ones, remainder is the dividend.
                     state    <= ST_DONE;
                     ready_q  <= 1'b1;
                     result_q <= bus.rem_sel_in ? bus.dividend_in : '1;
                  end else begin
                     state <= ST_BUSY;
                  end
               end
            end
            ST_BUSY: begin
               if (!bus.req_in) begin
                  // Consumer withdrew the request: abandon quietly, keep old result.
                  state <= ST_IDLE;
               end else begin
                  dq_q  <= {dq_q[XLEN-2:0], q_bit};
                  rem_q <= rem_nxt;
                  count <= count + CNT_W'(1);
                  if (count == CNT_W'(XLEN - 1)) begin
                     state    <= ST_DONE;
                     ready_q  <= 1'b1;
                     result_q <= rem_sel_q ? rem_nxt : {dq_q[XLEN-2:0], q_bit};
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ready_out  = ready_q;
   assign bus.result_out = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Randomized self-checking bench for div_seq against a plain-arithmetic reference.
module tb_div_seq;

   localparam int XLEN = 32;

   logic clk_in = 1'b0;
   logic reset_in;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] last_result;

   div_seq_if #(.XLEN(XLEN)) bus ();

   div_seq #(.XLEN(XLEN)) dut (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .bus      (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sel);
      if (b == 32'd0) return sel ? a : 32'hFFFF_FFFF;
      return sel ? (a % b) : (a / b);
   endfunction

   // One request; scrambles operand inputs after the start edge. keep_req leaves req high.
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sel, input bit keep_req);
      int          n;
      bit          seen;
      logic [31:0] exp;
      int          exp_lat;
      n       = 0;
      seen    = 1'b0;
      exp     = ref_div(a, b, sel);
      exp_lat = (b == 32'd0) ? 1 : XLEN + 1;
      @(negedge clk_in);
      bus.dividend_in = a;
      bus.divisor_in  = b;
      bus.rem_sel_in  = sel;
      bus.req_in      = 1'b1;
      while (!seen && n < 100) begin
         @(posedge clk_in); #1;
         n++;
         if (bus.ready_out) begin
            seen = 1'b1;
         end else begin
            @(negedge clk_in);
            bus.dividend_in = $urandom;
            bus.divisor_in  = $urandom;
            bus.rem_sel_in  = 1'($urandom);
         end
      end
      check({tag, " ready"}, 32'(seen), 32'd1);
      check({tag, " latency"}, n, exp_lat);
      check({tag, " result"}, bus.result_out, exp);
      @(posedge clk_in); #1;
      check({tag, " pulse"}, 32'(bus.ready_out), 32'd0);
      check({tag, " hold"}, bus.result_out, exp);
      last_result = exp;
      if (!keep_req) begin
         @(negedge clk_in);
         bus.req_in = 1'b0;
      end
   endtask

   initial begin
      int          ready_cnt;
      logic [31:0] a;
      logic [31:0] b;
      int          mode;

      reset_in        = 1'b1;
      bus.req_in      = 1'b0;
      bus.dividend_in = '0;
      bus.divisor_in  = '0;
      bus.rem_sel_in  = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      check("reset ready", 32'(bus.ready_out), 32'd0);
      check("reset result", bus.result_out, 32'd0);
      @(negedge clk_in);
      reset_in = 1'b0;

      run_div("q100_7", 32'd100, 32'd7, 1'b0, 1'b0);
      run_div("r100_7", 32'd100, 32'd7, 1'b1, 1'b0);
      run_div("qmax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
      run_div("q80_ff", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_div("r80_ff", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_div("q5_0", 32'd5, 32'd0, 1'b0, 1'b0);
      run_div("r5_0", 32'd5, 32'd0, 1'b1, 1'b0);
      run_div("q0_9", 32'd0, 32'd9, 1'b0, 1'b0);

      // Abort: drop the request partway through 1000/3.
      ready_cnt = 0;
      @(negedge clk_in);
      bus.dividend_in = 32'd1000;
      bus.divisor_in  = 32'd3;
      bus.rem_sel_in  = 1'b0;
      bus.req_in      = 1'b1;
      repeat (9) begin
         @(posedge clk_in); #1;
         if (bus.ready_out) ready_cnt++;
      end
      @(negedge clk_in);
      bus.req_in = 1'b0;
      repeat (40) begin
         @(posedge clk_in); #1;
         if (bus.ready_out) ready_cnt++;
      end
      check("abort no ready", ready_cnt, 0);
      check("abort held", bus.result_out, last_result);
      run_div("q9_3", 32'd9, 32'd3, 1'b0, 1'b0);

      // Reset during a division.
      @(negedge clk_in);
      bus.dividend_in = 32'd12345;
      bus.divisor_in  = 32'd17;
      bus.rem_sel_in  = 1'b0;
      bus.req_in      = 1'b1;
      repeat (14) @(posedge clk_in);
      @(negedge clk_in);
      reset_in   = 1'b1;
      bus.req_in = 1'b0;
      @(posedge clk_in); #1;
      check("midreset ready", 32'(bus.ready_out), 32'd0);
      check("midreset result", bus.result_out, 32'd0);
      @(negedge clk_in);
      reset_in = 1'b0;
      run_div("post_reset", 32'd12345, 32'd17, 1'b1, 1'b0);

      // Back-to-back requests with req held high throughout.
      run_div("b2b0", 32'hDEAD_BEEF, 32'd1234, 1'b0, 1'b1);
      run_div("b2b1", 32'h0BAD_F00D, 32'd77, 1'b1, 1'b1);
      run_div("b2b2", 32'd42, 32'd0, 1'b0, 1'b1);
      run_div("b2b3", 32'd42, 32'd5, 1'b1, 1'b0);

      // Randomized operands across several magnitude classes.
      for (int i = 0; i < 24; i++) begin
         mode = $urandom_range(0, 4);
         a    = $urandom;
         b    = $urandom;
         case (mode)
            0: b = 32'($urandom_range(1, 15));
            1: b = 32'd0;
            2: a = b >> $urandom_range(1, 8);
            3: b = b >> $urandom_range(0, 20);
            default: ;
         endcase
         run_div($sformatf("rnd%0d", i), a, b, 1'($urandom), 1'($urandom));
      end

      @(negedge clk_in);
      bus.req_in = 1'b0;
      repeat (2) @(posedge clk_in);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
